// File: rtl/gate_sweep_checker_if.sv
// Signal bundle between the sweep checker and the gate under test.
// master: the checker side; slave: the gate/host side.
interface gate_sweep_checker_if #(
    parameter int INPUT_SIZE  = 2,
    parameter int OUTPUT_SIZE = 1
);
    // start is a level request, accepted only while the checker is idle or done;
    // pass/err_count/first_fail are valid whenever done=1 and hold until relaunch.
    logic                   start;
    logic [INPUT_SIZE-1:0]  inputs;
    logic [OUTPUT_SIZE-1:0] outputs;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [INPUT_SIZE:0]    err_count;
    logic [INPUT_SIZE-1:0]  first_fail;

    modport master (
        input  start, outputs,
        output inputs, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, outputs,
        input  inputs, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps every input vector into a combinational gate, waits a settle interval,
// and compares the sampled output against a packed truth table.
module gate_sweep_checker #(
    parameter int INPUT_SIZE    = 2,
    parameter int OUTPUT_SIZE   = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter logic [(2**INPUT_SIZE)*OUTPUT_SIZE-1:0] EXPECTED = 4'b1110
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_sweep_checker_if.master bus,
    output logic [1:0]           dbg_state
);
    localparam int NVEC = 2 ** INPUT_SIZE;
    localparam int CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int EW   = INPUT_SIZE + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [INPUT_SIZE-1:0] LAST_VEC   = {INPUT_SIZE{1'b1}};
    localparam logic [CW-1:0]         SETTLE_END = CW'(SETTLE_CYCLES - 1);

    logic [1:0]             state;
    logic [INPUT_SIZE-1:0]  vec;
    logic [CW-1:0]          cnt;
    logic [OUTPUT_SIZE-1:0] exp_rom [NVEC];
    logic                   mismatch;

    for (genvar g = 0; g < NVEC; g++) begin : g_rom
        assign exp_rom[g] = EXPECTED[g*OUTPUT_SIZE +: OUTPUT_SIZE];
    end

    // Only meaningful in CHECK; anything the gate does during SETTLE is ignored.
    assign mismatch  = (bus.outputs != exp_rom[vec]);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            vec            <= '0;
            cnt            <= '0;
            bus.inputs     <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.err_count  <= '0;
            bus.first_fail <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state          <= SETTLE;
                        vec            <= '0;
                        cnt            <= '0;
                        bus.inputs     <= '0;
                        bus.err_count  <= '0;
                        bus.first_fail <= '0;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
                        bus.pass       <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_END) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        bus.err_count <= bus.err_count + EW'(1);
                        if (bus.err_count == '0) begin
                            bus.first_fail <= vec;
                        end
                    end
                    // Terminal vector is detected before increment so vec never wraps.
                    if (vec == LAST_VEC) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (bus.err_count == '0) && !mismatch;
                    end else begin
                        state      <= SETTLE;
                        vec        <= vec + INPUT_SIZE'(1);
                        bus.inputs <= vec + INPUT_SIZE'(1);
                        cnt        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
